reg_file_reader: RTL and testbench
==================================

# reg_file_reader

Read side of the 32 x 32-bit general-purpose register bank built from the per-bit enabled D flip-flop registers. The block holds the register array with its single write port, and serves two registered read ports to the decode stage. It also contains a dump sequencer that streams all 32 registers out over a valid/ready handshake for debug and test observation. Register 0 is hardwired to zero.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of registers; address width is log2(NUM_REGS) = 5

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- regWrite  in  1  write enable
- writeReg  in  5  write address
- writeData  in  32  write data
- rdEn  in  1  read request for both read ports
- readReg1  in  5  read port 1 address
- readReg2  in  5  read port 2 address
- readData1  out  32  registered read data, port 1
- readData2  out  32  registered read data, port 2
- readValid  out  1  high for one cycle when readData1/2 are updated
- dumpStart  in  1  pulse to begin a full-bank dump
- dumpData  out  32  current dump word
- dumpIdx  out  5  register index of dumpData
- dumpValid  out  1  dump word available
- dumpReady  in  1  consumer accepts the dump word
- dumpBusy  out  1  dump sequencer active

## Operation
- Reset (reset = 0, asynchronous): all registers clear to 0. readData1/2, readValid, dumpData, dumpIdx, dumpValid and dumpBusy clear to 0. The sequencer returns to IDLE.
- Write: on a clk edge with regWrite = 1 and writeReg != 0, reg[writeReg] <= writeData. Writes to register 0 are discarded.
- Read: on a clk edge with rdEn = 1, readDataN <= value of reg[readRegN] and readValid <= 1. Otherwise readValid <= 0 and readDataN holds its value.
- Bypass: if regWrite = 1, writeReg = readRegN, writeReg != 0 and rdEn = 1 in the same cycle, readDataN captures writeData (write-then-read semantics).
- Register 0 always reads 0, including under bypass.
- Dump FSM states:
  - IDLE: when dumpStart = 1, go to LOAD with index = 0 and dumpBusy = 1. dumpStart is ignored in any other state.
  - LOAD: dumpData <= reg[index], dumpIdx <= index, dumpValid <= 1, then go to WAIT. The same bypass rule applies: a same-cycle write to index is seen.
  - WAIT: hold dumpData, dumpIdx and dumpValid stable until dumpValid && dumpReady.
    - On handshake with index = 31: go to IDLE with dumpValid = 0 and dumpBusy = 0.
    - On handshake otherwise: index + 1, then go to LOAD, with dumpValid = 0 for that cycle.
- A word is sampled in LOAD. Later writes to that register do not change a word already presented.
- Normal reads and writes proceed fully in parallel with a dump.

## Timing
- Read latency: 1 cycle. Address presented in cycle N gives data and readValid in cycle N+1.
- Write visibility: the cycle of the write through bypass, or the next cycle from the array.
- Dump cadence: LOAD to dumpValid takes 1 cycle. With dumpReady held at 1, one word is delivered every 2 cycles, so a full dump from dumpStart to dumpBusy falling takes 64 cycles.
- dumpReady may be asserted before dumpValid. The handshake is evaluated only while dumpValid = 1.
- Reset asserted mid-dump: the FSM aborts immediately to IDLE and all outputs clear. No partial word remains valid after reset is released.
- index wraps from 31 only back to IDLE; it never rolls over to 0 within a dump.

## Test plan
- Reset, then read r5 and r31 -> readData1 = readData2 = 0 and readValid = 1 one cycle later.
- Write r3 = 0xDEADBEEF, then next cycle read r3 on port 1 and r0 on port 2 -> readData1 = 0xDEADBEEF, readData2 = 0.
- Write r7 = 0x12345678 with rdEn = 1 and readReg2 = 7 in the same cycle -> readData2 = 0x12345678 on the next edge (bypass). Write r0 = 0xFFFFFFFF with readReg1 = 0 -> readData1 = 0.
- Preload reg[i] = i * 0x01010101, pulse dumpStart, hold dumpReady = 1 -> 32 words in order with dumpIdx 0..31, word 0 = 0, and dumpBusy low exactly 64 cycles after dumpStart.
- During a dump, hold dumpReady = 0 for 5 cycles at idx 4 -> dumpData and dumpIdx stay stable at 4, no word skipped. A write to r4 during the stall does not alter the presented word.
- Assert reset at idx 10 of a dump -> dumpValid, dumpBusy and dumpIdx = 0 at once. A new dumpStart after release restarts from idx 0.

Source files
------------

// File: rtl/reg_file_reader.sv
// reg_file_reader: 32x32 register bank with two registered read ports and a handshaked dump sequencer
module reg_file_reader #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        regWrite,
   input  logic [$clog2(NUM_REGS)-1:0] writeReg,
   input  logic [DATA_W-1:0]           writeData,
   input  logic                        rdEn,
   input  logic [$clog2(NUM_REGS)-1:0] readReg1,
   input  logic [$clog2(NUM_REGS)-1:0] readReg2,
   output logic [DATA_W-1:0]           readData1,
   output logic [DATA_W-1:0]           readData2,
   output logic                        readValid,
   input  logic                        dumpStart,
   output logic [DATA_W-1:0]           dumpData,
   output logic [$clog2(NUM_REGS)-1:0] dumpIdx,
   output logic                        dumpValid,
   input  logic                        dumpReady,
   output logic                        dumpBusy
);
   localparam int AW = $clog2(NUM_REGS);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] rd1_data_q, rd2_data_q, dump_data_q, dump_data_d;
   logic              rd_valid_q, dump_valid_q, dump_valid_d, busy_q, busy_d;
   logic [AW-1:0]     idx_q, idx_d, dump_idx_q, dump_idx_d;
   state_t            state_q, state_d;
   logic [DATA_W-1:0] rd1_w, rd2_w, rdd_w;

   // Register 0 reads as zero; a same-cycle write to the addressed register is forwarded
   function automatic logic [DATA_W-1:0] fwd(input logic [AW-1:0] addr, input logic we,
                                             input logic [AW-1:0] wa, input logic [DATA_W-1:0] wd,
                                             input logic [DATA_W-1:0] rv);
      return (addr == '0) ? '0 : (we && wa == addr) ? wd : rv;
   endfunction

   assign rd1_w = fwd(readReg1, regWrite, writeReg, writeData, regs_q[readReg1]);
   assign rd2_w = fwd(readReg2, regWrite, writeReg, writeData, regs_q[readReg2]);
   assign rdd_w = fwd(idx_q, regWrite, writeReg, writeData, regs_q[idx_q]);

   // Register array write port; writes to register 0 are dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (regWrite && writeReg != '0) begin
         regs_q[writeReg] <= writeData;
      end
   end

   // Registered read ports; data holds when no read is requested
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd1_data_q <= '0;
         rd2_data_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rdEn;
         if (rdEn) begin
            rd1_data_q <= rd1_w;
            rd2_data_q <= rd2_w;
         end
      end
   end

   // Dump sequencer state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         dump_data_q  <= '0;
         dump_idx_q   <= '0;
         dump_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         dump_data_q  <= dump_data_d;
         dump_idx_q   <= dump_idx_d;
         dump_valid_q <= dump_valid_d;
         busy_q       <= busy_d;
      end
   end

   // Dump sequencer next state: sample a word in LOAD, present it in WAIT until accepted
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      dump_data_d  = dump_data_q;
      dump_idx_d   = dump_idx_q;
      dump_valid_d = dump_valid_q;
      busy_d       = busy_q;
      case (state_q)
         IDLE: if (dumpStart) begin
            state_d = LOAD;
            idx_d   = '0;
            busy_d  = 1'b1;
         end
         LOAD: begin
            dump_data_d  = rdd_w;
            dump_idx_d   = idx_q;
            dump_valid_d = 1'b1;
            state_d      = WAIT;
         end
         WAIT: if (dump_valid_q && dumpReady) begin
            dump_valid_d = 1'b0;
            if (idx_q == AW'(NUM_REGS - 1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               idx_d   = idx_q + AW'(1);
               state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign readData1 = rd1_data_q;
   assign readData2 = rd2_data_q;
   assign readValid = rd_valid_q;
   assign dumpData  = dump_data_q;
   assign dumpIdx   = dump_idx_q;
   assign dumpValid = dump_valid_q;
   assign dumpBusy  = busy_q;
endmodule

// File: tb/tb_reg_file_reader.sv
// tb_reg_file_reader: directed self-checking bench for reg_file_reader
module tb_reg_file_reader;
   logic        clk = 1'b0;
   logic        reset;
   logic        regWrite;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic        rdEn;
   logic [4:0]  readReg1, readReg2;
   logic [31:0] readData1, readData2;
   logic        readValid;
   logic        dumpStart;
   logic [31:0] dumpData;
   logic [4:0]  dumpIdx;
   logic        dumpValid, dumpReady, dumpBusy;
   int          checks = 0;
   int          errors = 0;

   reg_file_reader dut (
      .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
      .rdEn(rdEn), .readReg1(readReg1), .readReg2(readReg2), .readData1(readData1),
      .readData2(readData2), .readValid(readValid), .dumpStart(dumpStart), .dumpData(dumpData),
      .dumpIdx(dumpIdx), .dumpValid(dumpValid), .dumpReady(dumpReady), .dumpBusy(dumpBusy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_word(input logic [4:0] idx);
      int n = 0;
      while (!(dumpValid && dumpIdx == idx) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("wait_word_timeout", 32'(idx), 32'hFFFF_FFFF);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (dumpBusy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("wait_idle_timeout", 32'(dumpBusy), 32'h0);
   endtask

   initial begin
      int n, k;
      reset = 1'b0; regWrite = 1'b0; writeReg = '0; writeData = '0; rdEn = 1'b0;
      readReg1 = '0; readReg2 = '0; dumpStart = 1'b0; dumpReady = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_readValid", 32'(readValid), 32'h0);
      chk("rst_readData1", readData1, 32'h0);
      chk("rst_dumpBusy", 32'(dumpBusy), 32'h0);
      chk("rst_dumpValid", 32'(dumpValid), 32'h0);
      chk("rst_dumpIdx", 32'(dumpIdx), 32'h0);
      reset = 1'b1;
      @(negedge clk);
      rdEn = 1'b1; readReg1 = 5'd5; readReg2 = 5'd31;
      @(negedge clk);
      chk("rd_r5", readData1, 32'h0);
      chk("rd_r31", readData2, 32'h0);
      chk("rd_valid", 32'(readValid), 32'h1);
      rdEn = 1'b0;
      @(negedge clk);
      chk("rd_valid_drop", 32'(readValid), 32'h0);
      regWrite = 1'b1; writeReg = 5'd3; writeData = 32'hDEAD_BEEF;
      @(negedge clk);
      regWrite = 1'b0; rdEn = 1'b1; readReg1 = 5'd3; readReg2 = 5'd0;
      @(negedge clk);
      chk("rd_r3", readData1, 32'hDEAD_BEEF);
      chk("rd_r0", readData2, 32'h0);
      regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h1234_5678; readReg2 = 5'd7;
      @(negedge clk);
      chk("bypass_r7", readData2, 32'h1234_5678);
      chk("bypass_other_port", readData1, 32'hDEAD_BEEF);
      writeReg = 5'd0; writeData = 32'hFFFF_FFFF; readReg1 = 5'd0;
      @(negedge clk);
      chk("bypass_r0", readData1, 32'h0);
      regWrite = 1'b0;
      @(negedge clk);
      chk("array_r0", readData1, 32'h0);
      chk("array_r7", readData2, 32'h1234_5678);
      rdEn = 1'b0; readReg2 = 5'd3;
      @(negedge clk);
      chk("hold_data", readData2, 32'h1234_5678);
      chk("hold_valid", 32'(readValid), 32'h0);
      for (int i = 1; i < 32; i++) begin
         regWrite = 1'b1; writeReg = 5'(i); writeData = 32'(i) * 32'h0101_0101;
         @(negedge clk);
      end
      regWrite = 1'b0;
      dumpReady = 1'b1; dumpStart = 1'b1;
      @(negedge clk);
      dumpStart = 1'b0;
      chk("dump_busy_rise", 32'(dumpBusy), 32'h1);
      n = 0; k = 0;
      while (dumpBusy && n < 200) begin
         if (dumpValid) begin
            chk("dump_idx", 32'(dumpIdx), 32'(k));
            chk("dump_data", dumpData, 32'(k) * 32'h0101_0101);
            k++;
         end
         @(negedge clk);
         n++;
      end
      chk("dump_cycles", 32'(n), 32'd64);
      chk("dump_words", 32'(k), 32'd32);
      chk("dump_valid_end", 32'(dumpValid), 32'h0);
      dumpStart = 1'b1;
      @(negedge clk);
      dumpStart = 1'b0;
      wait_word(5'd3);
      @(negedge clk);
      dumpReady = 1'b0;
      @(negedge clk);
      chk("stall_idx", 32'(dumpIdx), 32'd4);
      chk("stall_data", dumpData, 32'h0404_0404);
      regWrite = 1'b1; writeReg = 5'd4; writeData = 32'hAAAA_5555;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         regWrite = 1'b0;
         chk("stall_hold_valid", 32'(dumpValid), 32'h1);
         chk("stall_hold_idx", 32'(dumpIdx), 32'd4);
         chk("stall_hold_data", dumpData, 32'h0404_0404);
      end
      dumpReady = 1'b1;
      @(negedge clk);
      chk("stall_gap_valid", 32'(dumpValid), 32'h0);
      @(negedge clk);
      chk("after_stall_idx", 32'(dumpIdx), 32'd5);
      chk("after_stall_data", dumpData, 32'h0505_0505);
      wait_idle();
      rdEn = 1'b1; readReg1 = 5'd4;
      @(negedge clk);
      rdEn = 1'b0;
      chk("stall_write_r4", readData1, 32'hAAAA_5555);
      dumpStart = 1'b1;
      @(negedge clk);
      dumpStart = 1'b0;
      wait_word(5'd10);
      reset = 1'b0;
      #1;
      chk("abort_valid", 32'(dumpValid), 32'h0);
      chk("abort_busy", 32'(dumpBusy), 32'h0);
      chk("abort_idx", 32'(dumpIdx), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("post_abort_valid", 32'(dumpValid), 32'h0);
      chk("post_abort_busy", 32'(dumpBusy), 32'h0);
      dumpStart = 1'b1;
      @(negedge clk);
      dumpStart = 1'b0;
      chk("restart_busy", 32'(dumpBusy), 32'h1);
      @(negedge clk);
      chk("restart_valid", 32'(dumpValid), 32'h1);
      chk("restart_idx", 32'(dumpIdx), 32'h0);
      chk("restart_data", dumpData, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("restart_idx1_cleared", dumpData, 32'h0);
      chk("restart_idx1", 32'(dumpIdx), 32'd1);
      rdEn = 1'b1; readReg1 = 5'd3; readReg2 = 5'd31;
      @(negedge clk);
      rdEn = 1'b0;
      chk("rst_cleared_r3", readData1, 32'h0);
      chk("rst_cleared_r31", readData2, 32'h0);
      wait_idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
